// File: rtl/slot_pkg.sv
// ---------------------------------------------------------------------------
// slot_pkg
// Shared definitions for the three-reel slot machine round logic: the round
// sequencer state encoding, symbol geometry and the payout multipliers.
// No ports; imported by slot_round_ctrl and referenced by slot_payout_eval.
// ---------------------------------------------------------------------------
package slot_pkg;

    localparam int SYM_W       = 4;
    localparam int NUM_SYMBOLS = 8;

    localparam int PAY_JACKPOT = 50;
    localparam int PAY_THREE   = 10;
    localparam int PAY_PAIR    = 2;

    localparam int JACKPOT_SYM = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPIN,
        ST_STOP_L,
        ST_STOP_C,
        ST_STOP_R,
        ST_EVAL,
        ST_PAYOUT
    } state_t;

endpackage

// File: rtl/slot_payout_eval.sv
// ---------------------------------------------------------------------------
// slot_payout_eval
// Combinational payout rule for one round: maps the three locked symbols and
// the bet to a win amount.
//   sym_l, sym_c, sym_r  in   SYM_W   locked reel symbols
//   bet                  in   BET_W   bet of the round
//   win                  out  WIN_W   payout (0 when nothing matches)
// ---------------------------------------------------------------------------
module slot_payout_eval #(
    parameter int SYM_W       = slot_pkg::SYM_W,
    parameter int BET_W       = 2,
    parameter int WIN_W       = 10,
    parameter int JACKPOT_SYM = slot_pkg::JACKPOT_SYM
) (
    input  logic [SYM_W-1:0] sym_l,
    input  logic [SYM_W-1:0] sym_c,
    input  logic [SYM_W-1:0] sym_r,
    input  logic [BET_W-1:0] bet,
    output logic [WIN_W-1:0] win
);

    logic [WIN_W-1:0] bet_ext;
    logic             three;
    logic             pair;

    assign bet_ext = WIN_W'(bet);
    assign three   = (sym_l == sym_c) && (sym_c == sym_r);
    // A left/right match with a different center does not pay.
    assign pair    = (sym_l == sym_c) || (sym_c == sym_r);

    always_comb begin
        win = '0;
        if (three) begin
            if (sym_l == SYM_W'(JACKPOT_SYM))
                win = bet_ext * WIN_W'(slot_pkg::PAY_JACKPOT);
            else
                win = bet_ext * WIN_W'(slot_pkg::PAY_THREE);
        end else if (pair) begin
            win = bet_ext * WIN_W'(slot_pkg::PAY_PAIR);
        end
    end

endmodule

// File: rtl/slot_round_ctrl.sv
// ---------------------------------------------------------------------------
// slot_round_ctrl
// Round sequencer for the three-reel slot machine. Owns the credit balance,
// takes a bet on a start press, spins the reels, stops them left->center->
// right through a start/done handshake with the per-reel pickers, evaluates
// the locked symbols and credits the payout.
//   clk         in   1          system clock
//   rst         in   1          asynchronous, active-low reset
//   start_n     in   1          debounced start button, press = 1->0 edge
//   bet         in   2          bet for the next round (0 is invalid)
//   tick        in   1          one-cycle reel-rate pulse
//   pick_done   in   3          per-reel picker completion (bit0 = left)
//   pick_sym    in   3*SYM_W    per-reel picked symbol
//   spin_en     out  3          per-reel spin enable
//   pick_start  out  3          one-cycle request to the per-reel picker
//   sym_l/c/r   out  SYM_W      locked final symbols
//   credits     out  CREDIT_W   current balance
//   last_win    out  CREDIT_W   payout of the most recent round
//   busy        out  1          high outside IDLE
//   round_done  out  1          one-cycle pulse when the payout lands
//   fault       out  1          sticky picker-timeout flag
// ---------------------------------------------------------------------------
module slot_round_ctrl
    import slot_pkg::state_t,
           slot_pkg::ST_IDLE, slot_pkg::ST_SPIN, slot_pkg::ST_STOP_L,
           slot_pkg::ST_STOP_C, slot_pkg::ST_STOP_R, slot_pkg::ST_EVAL,
           slot_pkg::ST_PAYOUT;
#(
    parameter int SYM_W          = 4,
    parameter int CREDIT_W       = 10,
    parameter int START_CREDITS  = 100,
    parameter int MIN_SPIN_TICKS = 17,
    parameter int PICK_TIMEOUT   = 255,
    parameter int JACKPOT_SYM    = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_n,
    input  logic [1:0]            bet,
    input  logic                  tick,
    input  logic [2:0]            pick_done,
    input  logic [3*SYM_W-1:0]    pick_sym,
    output logic [2:0]            spin_en,
    output logic [2:0]            pick_start,
    output logic [SYM_W-1:0]      sym_l,
    output logic [SYM_W-1:0]      sym_c,
    output logic [SYM_W-1:0]      sym_r,
    output logic [CREDIT_W-1:0]   credits,
    output logic [CREDIT_W-1:0]   last_win,
    output logic                  busy,
    output logic                  round_done,
    output logic                  fault
);

    localparam int TICK_W = $clog2(MIN_SPIN_TICKS + 1);
    localparam int TO_W   = $clog2(PICK_TIMEOUT + 1);

    // Credit balance add that pins at the top of the counter range.
    function automatic logic [CREDIT_W-1:0] sat_add(
        input logic [CREDIT_W-1:0] a,
        input logic [CREDIT_W-1:0] b
    );
        logic [CREDIT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CREDIT_W] ? {CREDIT_W{1'b1}} : sum[CREDIT_W-1:0];
    endfunction

    state_t              state;
    logic                start_q;
    logic [1:0]          bet_r;
    logic [TICK_W-1:0]   tick_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic                pick_wait;
    logic [CREDIT_W-1:0] win_r;
    logic [CREDIT_W-1:0] win;

    logic                press;
    logic                in_stop;
    logic [2:0]          cur_mask;
    logic [SYM_W-1:0]    cur_sym;
    state_t              stop_next;
    logic                done_hit;
    logic                to_hit;
    logic [SYM_W-1:0]    lock_sym;

    assign press = start_q & ~start_n;

    // Which reel the current STOP state is working on.
    always_comb begin
        in_stop   = 1'b0;
        cur_mask  = 3'b000;
        cur_sym   = '0;
        stop_next = ST_IDLE;
        case (state)
            ST_STOP_L: begin
                in_stop   = 1'b1;
                cur_mask  = 3'b001;
                cur_sym   = pick_sym[0*SYM_W +: SYM_W];
                stop_next = ST_STOP_C;
            end
            ST_STOP_C: begin
                in_stop   = 1'b1;
                cur_mask  = 3'b010;
                cur_sym   = pick_sym[1*SYM_W +: SYM_W];
                stop_next = ST_STOP_R;
            end
            ST_STOP_R: begin
                in_stop   = 1'b1;
                cur_mask  = 3'b100;
                cur_sym   = pick_sym[2*SYM_W +: SYM_W];
                stop_next = ST_EVAL;
            end
            default: ;
        endcase
    end

    // pick_start is still high during the request cycle; a done seen then
    // belongs to no accepted request, so acceptance waits one cycle.
    assign done_hit = in_stop && pick_wait && (pick_start == 3'b000)
                      && ((pick_done & cur_mask) != 3'b000);
    assign to_hit   = in_stop && pick_wait
                      && (to_cnt == TO_W'(PICK_TIMEOUT - 1));
    assign lock_sym = done_hit ? cur_sym : '0;

    slot_payout_eval #(
        .SYM_W       (SYM_W),
        .BET_W       (2),
        .WIN_W       (CREDIT_W),
        .JACKPOT_SYM (JACKPOT_SYM)
    ) u_eval (
        .sym_l (sym_l),
        .sym_c (sym_c),
        .sym_r (sym_r),
        .bet   (bet_r),
        .win   (win)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            start_q    <= 1'b1;
            bet_r      <= '0;
            tick_cnt   <= '0;
            to_cnt     <= '0;
            pick_wait  <= 1'b0;
            win_r      <= '0;
            spin_en    <= 3'b000;
            pick_start <= 3'b000;
            sym_l      <= SYM_W'(1);
            sym_c      <= SYM_W'(0);
            sym_r      <= SYM_W'(2);
            credits    <= CREDIT_W'(START_CREDITS);
            last_win   <= '0;
            busy       <= 1'b0;
            round_done <= 1'b0;
            fault      <= 1'b0;
        end else begin
            start_q    <= start_n;
            pick_start <= 3'b000;
            round_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (press && (bet != 2'd0) && (credits >= CREDIT_W'(bet))) begin
                        credits  <= credits - CREDIT_W'(bet);
                        bet_r    <= bet;
                        spin_en  <= 3'b111;
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_SPIN;
                    end
                end

                ST_SPIN: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == TICK_W'(MIN_SPIN_TICKS - 1)) begin
                            pick_wait <= 1'b0;
                            state     <= ST_STOP_L;
                        end
                    end
                end

                ST_STOP_L, ST_STOP_C, ST_STOP_R: begin
                    if (!pick_wait) begin
                        if (tick) begin
                            pick_start <= cur_mask;
                            pick_wait  <= 1'b1;
                            to_cnt     <= '0;
                        end
                    end else if (done_hit || to_hit) begin
                        // A tick arriving with done is swallowed here; the
                        // next reel waits for a later tick.
                        case (state)
                            ST_STOP_L: sym_l <= lock_sym;
                            ST_STOP_C: sym_c <= lock_sym;
                            default:   sym_r <= lock_sym;
                        endcase
                        if (!done_hit)
                            fault <= 1'b1;
                        spin_en   <= spin_en & ~cur_mask;
                        pick_wait <= 1'b0;
                        state     <= stop_next;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                ST_EVAL: begin
                    win_r <= win;
                    state <= ST_PAYOUT;
                end

                ST_PAYOUT: begin
                    credits    <= sat_add(credits, win_r);
                    last_win   <= win_r;
                    round_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slot_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_slot_round_ctrl
// Randomized bench for slot_round_ctrl. A round-level reference model
// (expected balance, locked symbols, spin enables, flags) is advanced by the
// stimulus process at the cycle each rule says a change lands; a separate
// process compares every DUT output against it on each falling edge.
// ---------------------------------------------------------------------------
module tb_slot_round_ctrl;

    localparam int SYM_W    = 4;
    localparam int CREDIT_W = 10;
    localparam int CR_MAX   = (1 << CREDIT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  start_n = 1'b1;
    logic [1:0]            bet = 2'd0;
    logic                  tick = 1'b0;
    logic [2:0]            pick_done = 3'b000;
    logic [3*SYM_W-1:0]    pick_sym = '0;
    logic [2:0]            spin_en;
    logic [2:0]            pick_start;
    logic [SYM_W-1:0]      sym_l, sym_c, sym_r;
    logic [CREDIT_W-1:0]   credits;
    logic [CREDIT_W-1:0]   last_win;
    logic                  busy;
    logic                  round_done;
    logic                  fault;

    slot_round_ctrl #(
        .SYM_W          (SYM_W),
        .CREDIT_W       (CREDIT_W),
        .START_CREDITS  (100),
        .MIN_SPIN_TICKS (17),
        .PICK_TIMEOUT   (255),
        .JACKPOT_SYM    (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_n    (start_n),
        .bet        (bet),
        .tick       (tick),
        .pick_done  (pick_done),
        .pick_sym   (pick_sym),
        .spin_en    (spin_en),
        .pick_start (pick_start),
        .sym_l      (sym_l),
        .sym_c      (sym_c),
        .sym_r      (sym_r),
        .credits    (credits),
        .last_win   (last_win),
        .busy       (busy),
        .round_done (round_done),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b1;

    // Reference state
    int exp_spin    = 0;
    int exp_ps      = 0;
    int exp_sym[3]  = '{1, 0, 2};
    int exp_credits = 100;
    int exp_last    = 0;
    int exp_busy    = 0;
    int exp_rd      = 0;
    int exp_fault   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("spin_en",    int'(spin_en),    exp_spin);
            check("pick_start", int'(pick_start), exp_ps);
            check("sym_l",      int'(sym_l),      exp_sym[0]);
            check("sym_c",      int'(sym_c),      exp_sym[1]);
            check("sym_r",      int'(sym_r),      exp_sym[2]);
            check("credits",    int'(credits),    exp_credits);
            check("last_win",   int'(last_win),   exp_last);
            check("busy",       int'(busy),       exp_busy);
            check("round_done", int'(round_done), exp_rd);
            check("fault",      int'(fault),      exp_fault);
        end
    end

    function automatic int payout(input int l, input int c, input int r, input int b);
        if (l == c && c == r) return b * ((l == 7) ? 50 : 10);
        if (l == c || c == r) return b * 2;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        tick      = 1'b0;
        pick_done = 3'b000;
    endtask

    // Random done pulses on reels other than cur, random symbol bus.
    task automatic noise(input int cur);
        for (int r = 0; r < 3; r++)
            if (r != cur) pick_done[r] = ($urandom_range(0, 3) == 0);
        pick_sym = 12'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_pulses();
        start_n     = 1'b1;
        bet         = 2'd0;
        exp_spin    = 0;
        exp_ps      = 0;
        exp_sym[0]  = 1;
        exp_sym[1]  = 0;
        exp_sym[2]  = 2;
        exp_credits = 100;
        exp_last    = 0;
        exp_busy    = 0;
        exp_rd      = 0;
        exp_fault   = 0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic run_round(input int b, input int s0, input int s1, input int s2,
                             input int withhold, input bit abort_after_l);
        int  syms[3];
        int  waited;
        int  idle;
        bit  legal;
        syms[0] = s0;
        syms[1] = s1;
        syms[2] = s2;

        bet     = 2'(b);
        start_n = 1'b0;
        step();
        legal = (b != 0) && (exp_credits >= b);
        if (legal) begin
            exp_credits = exp_credits - b;
            exp_spin    = 7;
            exp_busy    = 1;
        end
        start_n = 1'b1;
        if (!legal) begin
            step();
            step();
            return;
        end

        // Spin: 17 ticks, with bet changes, button noise and stray dones.
        for (int i = 0; i < 17; i++) begin
            idle = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++) begin
                bet     = 2'($urandom);
                start_n = ($urandom_range(0, 3) != 0);
                noise(-1);
                step();
                clear_pulses();
            end
            tick = 1'b1;
            noise(-1);
            step();
            clear_pulses();
        end
        start_n = 1'b1;

        for (int x = 0; x < 3; x++) begin
            idle = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++) begin
                noise(x);
                step();
                clear_pulses();
            end
            tick = 1'b1;
            noise(x);
            step();
            exp_ps = 1 << x;
            clear_pulses();

            // Request cycle: a done here must not be taken.
            tick = $urandom_range(0, 1);
            noise(x);
            if ($urandom_range(0, 1) == 1) begin
                pick_done[x] = 1'b1;
                pick_sym[x*SYM_W +: SYM_W] = 4'((syms[x] + 3) % 8);
            end
            step();
            exp_ps = 0;
            clear_pulses();
            waited = 1;

            if (x == withhold) begin
                while (waited < 255) begin
                    tick = ($urandom_range(0, 7) == 0);
                    noise(x);
                    step();
                    waited++;
                    clear_pulses();
                    if (waited == 255) begin
                        exp_fault  = 1;
                        exp_sym[x] = 0;
                        exp_spin   = exp_spin & ~(1 << x);
                    end
                end
            end else begin
                idle = $urandom_range(0, 4);
                for (int j = 0; j < idle; j++) begin
                    tick = ($urandom_range(0, 3) == 0);
                    noise(x);
                    step();
                    clear_pulses();
                end
                noise(x);
                tick         = $urandom_range(0, 1);
                pick_done[x] = 1'b1;
                pick_sym[x*SYM_W +: SYM_W] = 4'(syms[x]);
                step();
                exp_sym[x] = syms[x];
                exp_spin   = exp_spin & ~(1 << x);
                clear_pulses();
            end

            if (abort_after_l && x == 0) begin
                step();
                do_reset();
                // Stray completions after release must do nothing.
                for (int j = 0; j < 4; j++) begin
                    tick      = 1'b1;
                    pick_done = 3'b111;
                    pick_sym  = 12'($urandom);
                    step();
                    clear_pulses();
                end
                return;
            end
        end

        step();
        step();
        exp_last    = payout(exp_sym[0], exp_sym[1], exp_sym[2], b);
        exp_credits = (exp_credits + exp_last > CR_MAX) ? CR_MAX : exp_credits + exp_last;
        exp_rd      = 1;
        exp_busy    = 0;
        step();
        exp_rd = 0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, mode, s0, s1, s2, wh;

        do_reset();
        check("reset_credits", int'(credits), 100);
        check("reset_sym_l",   int'(sym_l),   1);
        check("reset_sym_c",   int'(sym_c),   0);
        check("reset_sym_r",   int'(sym_r),   2);
        check("reset_busy",    int'(busy),    0);

        run_round(1, 3, 3, 3, -1, 1'b0);
        check("three_credits", int'(credits),  109);
        check("three_win",     int'(last_win), 10);

        do_reset();
        run_round(3, 7, 7, 7, -1, 1'b0);
        check("jackpot_credits", int'(credits),  247);
        check("jackpot_win",     int'(last_win), 150);

        run_round(2, 1, 2, 2, -1, 1'b0);
        check("pair_win",     int'(last_win), 4);
        check("pair_credits", int'(credits),  249);
        run_round(2, 1, 2, 5, -1, 1'b0);
        check("lose_win",     int'(last_win), 0);
        check("lose_credits", int'(credits),  247);

        run_round(1, 4, 5, 6, 1, 1'b0);
        check("timeout_fault", int'(fault),   1);
        check("timeout_sym_c", int'(sym_c),   0);
        check("timeout_sym_r", int'(sym_r),   6);
        check("timeout_cred",  int'(credits), 246);

        run_round(1, 3, 3, 3, -1, 1'b1);
        check("abort_credits", int'(credits), 100);
        check("abort_fault",   int'(fault),   0);
        check("abort_sym_l",   int'(sym_l),   1);
        check("abort_busy",    int'(busy),    0);

        for (int i = 0; i < 33; i++) run_round(3, 0, 1, 2, -1, 1'b0);
        check("drain_credits", int'(credits), 1);
        run_round(2, 3, 3, 3, -1, 1'b0);
        run_round(0, 3, 3, 3, -1, 1'b0);
        check("short_busy",    int'(busy),    0);
        check("short_credits", int'(credits), 1);
        run_round(1, 0, 1, 2, -1, 1'b0);
        run_round(1, 3, 3, 3, -1, 1'b0);
        check("empty_credits", int'(credits), 0);
        check("empty_busy",    int'(busy),    0);

        do_reset();
        for (int i = 0; i < 7; i++) run_round(3, 7, 7, 7, -1, 1'b0);
        check("sat_credits", int'(credits), 1023);

        for (int i = 0; i < 40; i++) begin
            b    = $urandom_range(0, 3);
            mode = $urandom_range(0, 3);
            s0   = $urandom_range(0, 7);
            s1   = (mode == 0 || mode == 1) ? s0 : $urandom_range(0, 7);
            s2   = (mode == 0) ? s0 : $urandom_range(0, 7);
            wh   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : -1;
            run_round(b, s0, s1, s2, wh, 1'b0);
            if (i == 20) begin
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
